// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, issues word fetches, buffers returned instructions.
// Latency: request accepted in cycle N, response in cycle N+k (k>=1), instruction at output in cycle N+k+1.
// Backpressure: stall_dec_in holds the head entry. New requests are issued only while the outstanding count
//   plus the buffered count is below the buffer depth. Optional `FETCH_PERF_CNT_EN adds bubble/redirect counters.

// Small generic FIFO with a synchronous flush. The caller must never push when full or pop when empty.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Explicit wrap so that a depth which is not a power of two still works.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage is write-only on push; contents need no reset because count qualifies them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
endmodule

// Fetch stage top: PC register, request credit logic, PC tag queue, instruction buffer, redirect drain FSM.
// Latency: one cycle from response to output; outputs come straight from buffer registers.
// Backpressure: stall_dec_in freezes the head; redirect flushes and drains stale responses.
module fetch_stage #(
  parameter int                  ARCH_LEN        = 32,
  parameter int                  INST_LEN        = 32,
  parameter logic [ARCH_LEN-1:0] RESET_PC        = 32'h0000_1000,
  parameter int                  FIFO_DEPTH      = 2,
  parameter int                  MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ARCH_LEN-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [INST_LEN-1:0] imem_rsp_data,
  input  logic                stall_dec_in,
  input  logic                redirect_valid,
  input  logic [ARCH_LEN-1:0] redirect_pc,
  output logic [INST_LEN-1:0] inst_fetched_out,
  output logic [ARCH_LEN-1:0] pc_out,
  output logic                fetch_valid_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         bubble_cnt_out,
  output logic [31:0]         redirect_cnt_out
`endif
);
  localparam int                  FCW          = $clog2(FIFO_DEPTH + 1);
  localparam int                  TCW          = $clog2(MAX_OUTSTANDING + 1);
  localparam int                  EW           = INST_LEN + ARCH_LEN;
  localparam logic [31:0]         FIFO_DEPTH_U = FIFO_DEPTH;
  localparam logic [31:0]         MAX_OUT_U    = MAX_OUTSTANDING;
  localparam logic [INST_LEN-1:0] NOP_INST     = INST_LEN'(32'h0000_0013);

  typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ARCH_LEN-1:0] pc_reg;

  // Outstanding requests are exactly the entries waiting in the PC tag queue.
  logic [TCW-1:0]      tag_count;
  logic [ARCH_LEN-1:0] tag_pc;
  logic [FCW-1:0]      fifo_count;
  logic [EW-1:0]       fifo_head;

  logic [31:0] out_ext;
  logic [31:0] cnt_ext;
  logic [31:0] out_nxt;
  logic        req_fire;
  logic        rsp_ok;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_empty;

  assign out_ext    = 32'(tag_count);
  assign cnt_ext    = 32'(fifo_count);
  assign fifo_empty = (fifo_count == '0);
  assign req_fire   = imem_req_valid & imem_req_ready;
  // A response with nothing outstanding would be a protocol error; ignoring it keeps the tag queue sane.
  assign rsp_ok     = imem_rsp_valid & (tag_count != '0);
  assign out_nxt    = out_ext + 32'(req_fire) - 32'(rsp_ok);

  // Responses only land in the buffer during normal fetch and never in a redirect cycle.
  assign fifo_push  = rsp_ok & (state == FETCH) & ~redirect_valid;
  assign fifo_pop   = ~fifo_empty & ~stall_dec_in & ~redirect_valid;
  assign imem_req_addr = pc_reg;

  fetch_fifo #(.WIDTH(ARCH_LEN), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc_reg),
    .pop       (rsp_ok),
    .head_data (tag_pc),
    .count     (tag_count)
  );

  fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data ({imem_rsp_data, tag_pc}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  // State register for the fetch/drain controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Leave FETCH on a redirect with stale requests in flight; return once they have all come back.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (redirect_valid && (out_nxt != 32'd0)) state_nxt = DRAIN;
      DRAIN:   if (out_nxt == 32'd0)                      state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Request credit and the decode-facing outputs, all derived from registered state.
  always_comb begin
    imem_req_valid   = ~rst & (state == FETCH) & ~redirect_valid &
                       (out_ext < MAX_OUT_U) & ((out_ext + cnt_ext) < FIFO_DEPTH_U);
    inst_fetched_out = NOP_INST;
    pc_out           = '0;
    fetch_valid_out  = 1'b0;
    if (!fifo_empty) begin
      inst_fetched_out = fifo_head[EW-1:ARCH_LEN];
      pc_out           = fifo_head[ARCH_LEN-1:0];
      fetch_valid_out  = 1'b1;
    end
  end

  // PC register: redirect wins over sequential advance; the redirect target is forced word-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc_reg <= RESET_PC;
    else if (redirect_valid) pc_reg <= redirect_pc & ~ARCH_LEN'(3);
    else if (req_fire)       pc_reg <= pc_reg + ARCH_LEN'(4);
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating count of cycles with no valid instruction presented to decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           bubble_cnt_out <= '0;
    else if (!fetch_valid_out && bubble_cnt_out != '1) bubble_cnt_out <= bubble_cnt_out + 32'd1;
  end

  // Saturating count of redirect cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            redirect_cnt_out <= '0;
    else if (redirect_valid && redirect_cnt_out != '1)  redirect_cnt_out <= redirect_cnt_out + 32'd1;
  end
`else
  // Without the counters nothing extra is built.
`endif

  // The credit rule guarantees the instruction buffer and tag queue never overflow.
  ap_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
    fifo_push |-> ((cnt_ext < FIFO_DEPTH_U) || fifo_pop));
  ap_no_tag_overflow: assert property (@(posedge clk) disable iff (rst)
    req_fire |-> ((out_ext < MAX_OUT_U) || rsp_ok));
endmodule
